// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle shared by the I side, the D side and the single memory port.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  i_valid_i;
  logic                  i_ready_o;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic [DATA_WIDTH-1:0] i_wdata_i;
  logic [BE_WIDTH-1:0]   i_we_i;
  logic [DATA_WIDTH-1:0] i_rdata_o;

  logic                  d_valid_i;
  logic                  d_ready_o;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [BE_WIDTH-1:0]   d_we_i;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_WIDTH-1:0]   mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic [1:0]            owner_o;

  modport slave (
    input  i_valid_i, i_addr_i, i_wdata_i, i_we_i,
    output i_ready_o, i_rdata_o,
    input  d_valid_i, d_addr_i, d_wdata_i, d_we_i,
    output d_ready_o, d_rdata_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
    input  mem_ready_i, mem_rdata_i,
    output owner_o
  );

  modport master (
    output i_valid_i, i_addr_i, i_wdata_i, i_we_i,
    input  i_ready_o, i_rdata_o,
    output d_valid_i, d_addr_i, d_wdata_i, d_we_i,
    input  d_ready_o, d_rdata_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
    output mem_ready_i, mem_rdata_i,
    input  owner_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D).
// D has fixed priority; I wins once it has lost STARVE_LIMIT contested rounds in a row.
//
// state   | meaning
// IDLE    | arbitrate; winner drives memory combinationally, may complete same cycle
// BUSY_I  | I transaction outstanding, memory driven from latched request
// BUSY_D  | D transaction outstanding, memory driven from latched request
// DRAIN   | owner withdrew; wait out the memory response and discard it
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Encoding doubles as owner_o.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    DRAIN  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [BW-1:0]         req_we_q;

  logic                  latch_en;
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BW-1:0]         mem_we;
  logic                  i_ready;
  logic                  d_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (latch_en) begin
        req_addr_q  <= mem_addr;
        req_wdata_q <= mem_wdata;
        req_we_q    <= mem_we;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    latch_en  = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = req_addr_q;
    mem_wdata = req_wdata_q;
    mem_we    = req_we_q;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_valid_i && !(bus.i_valid_i && starve_q == LIMIT)) begin
          mem_valid = 1'b1;
          mem_addr  = bus.d_addr_i;
          mem_wdata = bus.d_wdata_i;
          mem_we    = bus.d_we_i;
          latch_en  = 1'b1;
          d_ready   = bus.mem_ready_i;
          if (bus.i_valid_i && starve_q != LIMIT) starve_d = starve_q + SW'(1);
          if (!bus.mem_ready_i) state_d = BUSY_D;
        end else if (bus.i_valid_i) begin
          mem_valid = 1'b1;
          mem_addr  = bus.i_addr_i;
          mem_wdata = bus.i_wdata_i;
          mem_we    = bus.i_we_i;
          latch_en  = 1'b1;
          i_ready   = bus.mem_ready_i;
          starve_d  = '0;
          if (!bus.mem_ready_i) state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        mem_valid = 1'b1;
        if (bus.mem_ready_i) begin
          i_ready = bus.i_valid_i;
          state_d = IDLE;
        end else if (!bus.i_valid_i) begin
          state_d = DRAIN;
        end
      end
      BUSY_D: begin
        mem_valid = 1'b1;
        if (bus.mem_ready_i) begin
          d_ready = bus.d_valid_i;
          state_d = IDLE;
        end else if (!bus.d_valid_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        mem_valid = 1'b1;
        if (bus.mem_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE outputs are combinational from the requesters, so gate them with reset
  // to keep the memory request down while rst_n is low.
  assign bus.mem_valid_o = mem_valid & rst_n;
  assign bus.i_ready_o   = i_ready & rst_n;
  assign bus.d_ready_o   = d_ready & rst_n;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.mem_we_o    = mem_we;
  assign bus.i_rdata_o   = bus.mem_rdata_i;
  assign bus.d_rdata_o   = bus.mem_rdata_i;
  assign bus.owner_o     = state_q;
endmodule
